instr_encoder: RTL and testbench

Streaming RV32 instruction encoder and program writer, the inverse of the instruction decoder. It accepts decoded-form requests (op_type, register indices, offset, immediate) over a valid/ready handshake. It packs each request into a 32-bit instruction word and writes it to instruction memory through a registered valid/ready write port at consecutive word addresses. A finish request appends a 32'h0 (I_NULL) terminator. Used by the bench/loader side to build test programs in instruction memory.

---
 rtl/instr_encoder_pkg.sv | 66 ++++++
 rtl/instr_encoder_pack.sv | 82 ++++++++
 rtl/instr_encoder.sv | 111 +++++++++++
 tb/tb_instr_encoder.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared instruction codes, RV32 opcode/funct constants and encoder FSM states.
package instr_encoder_pkg;

    // Decoded-form operation codes carried on in_op_type
    localparam logic [4:0] I_NULL  = 5'd0;
    localparam logic [4:0] I_ADD   = 5'd1;
    localparam logic [4:0] I_SUB   = 5'd2;
    localparam logic [4:0] I_MUL   = 5'd3;
    localparam logic [4:0] I_MULH  = 5'd4;
    localparam logic [4:0] I_XOR   = 5'd5;
    localparam logic [4:0] I_OR    = 5'd6;
    localparam logic [4:0] I_AND   = 5'd7;
    localparam logic [4:0] I_ADDI  = 5'd8;
    localparam logic [4:0] I_LW    = 5'd9;
    localparam logic [4:0] I_SW    = 5'd10;
    localparam logic [4:0] I_BEQ   = 5'd11;
    localparam logic [4:0] I_BNE   = 5'd12;
    localparam logic [4:0] I_BLT   = 5'd13;
    localparam logic [4:0] I_BGE   = 5'd14;
    localparam logic [4:0] I_JAL   = 5'd15;
    localparam logic [4:0] I_LUI   = 5'd16;
    localparam logic [4:0] I_AUIPC = 5'd17;
    localparam logic [4:0] I_ERR   = 5'd31;

    // RV32 major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // funct3 values shared by decoder and encoder
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_MULH = 3'b001;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;

    // funct7 values
    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_SUB  = 7'h20;
    localparam logic [6:0] F7_MUL  = 7'h01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_TERM,
        ST_DONE
    } enc_state_t;

    // Assemble an R-type word from its fields
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OPC_OP};
    endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational field packing of one decoded request plus its legality check.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [4:0]  op_type,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic [31:0] offset,
    input  logic [31:0] immediate,
    output logic [31:0] word,
    output logic        legal
);

    logic addi_ok;
    logic branch_ok;
    logic jal_ok;
    logic upper_ok;
    logic mem_ok;

    // Range checks: upper bits must be a pure sign extension (or zero for memory offsets)
    assign addi_ok   = (&immediate[31:11]) || !(|immediate[31:11]);
    assign branch_ok = !offset[0] && ((&offset[31:12]) || !(|offset[31:12]));
    assign jal_ok    = !offset[0] && ((&offset[31:20]) || !(|offset[31:20]));
    assign upper_ok  = !(|immediate[11:0]);
    assign mem_ok    = !(|offset[31:12]);

    // Select the instruction format and scatter the immediate bits into place
    always_comb begin
        word  = 32'h0;
        legal = 1'b0;
        case (op_type)
            I_ADD:   begin word = enc_r(F7_BASE, rs2, rs1, F3_ADD,  rd); legal = 1'b1; end
            I_SUB:   begin word = enc_r(F7_SUB,  rs2, rs1, F3_ADD,  rd); legal = 1'b1; end
            I_MUL:   begin word = enc_r(F7_MUL,  rs2, rs1, F3_ADD,  rd); legal = 1'b1; end
            I_MULH:  begin word = enc_r(F7_MUL,  rs2, rs1, F3_MULH, rd); legal = 1'b1; end
            I_XOR:   begin word = enc_r(F7_BASE, rs2, rs1, F3_XOR,  rd); legal = 1'b1; end
            I_OR:    begin word = enc_r(F7_BASE, rs2, rs1, F3_OR,   rd); legal = 1'b1; end
            I_AND:   begin word = enc_r(F7_BASE, rs2, rs1, F3_AND,  rd); legal = 1'b1; end
            I_ADDI: begin
                word  = {immediate[11:0], rs1, F3_ADD, rd, OPC_OPIMM};
                legal = addi_ok;
            end
            I_LW: begin
                word  = {offset[11:0], rs1, F3_WORD, rd, OPC_LOAD};
                legal = mem_ok;
            end
            I_SW: begin
                word  = {offset[11:5], rs2, rs1, F3_WORD, offset[4:0], OPC_STORE};
                legal = mem_ok;
            end
            I_BEQ, I_BNE, I_BLT, I_BGE: begin
                word = {offset[12], offset[10:5], rs2, rs1, 3'b000,
                        offset[4:1], offset[11], OPC_BRANCH};
                case (op_type)
                    I_BNE:   word[14:12] = F3_BNE;
                    I_BLT:   word[14:12] = F3_BLT;
                    I_BGE:   word[14:12] = F3_BGE;
                    default: word[14:12] = F3_BEQ;
                endcase
                legal = branch_ok;
            end
            I_JAL: begin
                word  = {offset[20], offset[10:1], offset[11], offset[19:12], rd, OPC_JAL};
                legal = jal_ok;
            end
            I_LUI: begin
                word  = {immediate[31:12], rd, OPC_LUI};
                legal = upper_ok;
            end
            I_AUIPC: begin
                word  = {immediate[31:12], rd, OPC_AUIPC};
                legal = upper_ok;
            end
            default: begin
                word  = 32'h0;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming instruction encoder: packs requests and writes them to consecutive
// word addresses, finishing each program with a null terminator word.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op_type,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic [31:0]       in_offset,
    input  logic [31:0]       in_immediate,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_word,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST = '1;

    enc_state_t        state;
    logic [ADDR_W-1:0] next_addr;
    logic [31:0]       pack_word;
    logic              pack_legal;
    logic              out_free;
    logic              accept;

    instr_pack u_pack (
        .op_type   (in_op_type),
        .rs1       (in_rs1),
        .rs2       (in_rs2),
        .rd        (in_rd),
        .offset    (in_offset),
        .immediate (in_immediate),
        .word      (pack_word),
        .legal     (pack_legal)
    );

    // The last address is kept free so the terminator always has a slot
    assign out_free = !out_valid || out_ready;
    assign in_ready = (state == ST_RUN) && out_free && (next_addr != LAST);
    assign accept   = in_valid && in_ready;
    assign busy     = (state == ST_RUN) || (state == ST_TERM);
    assign done     = (state == ST_DONE);

    // Program-writer FSM with the output register, address counter and status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            next_addr <= BASE;
            out_addr  <= BASE;
            out_word  <= 32'h0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            count     <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state     <= ST_RUN;
                        next_addr <= BASE;
                        count     <= '0;
                        err       <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        if (pack_legal) begin
                            out_word  <= pack_word;
                            out_addr  <= next_addr;
                            out_valid <= 1'b1;
                            next_addr <= next_addr + ADDR_W'(1);
                            count     <= count + (ADDR_W + 1)'(1);
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    if (finish) begin
                        state <= ST_TERM;
                    end
                end
                ST_TERM: begin
                    if (out_free) begin
                        out_word  <= 32'h0;
                        out_addr  <= next_addr;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vector table, hand-written
// backpressure/finish/small-address/reset sequences, and a randomized run.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, finish, in_valid, out_ready;
    logic [4:0]  in_op_type, in_rs1, in_rs2, in_rd;
    logic [31:0] in_offset, in_immediate;
    logic        in_ready, out_valid, busy, done, err;
    logic [9:0]  out_addr;
    logic [31:0] out_word;
    logic [10:0] count;

    logic        sm_start, sm_finish, sm_in_valid, sm_out_ready;
    logic        sm_in_ready, sm_out_valid, sm_busy, sm_done, sm_err;
    logic [1:0]  sm_out_addr;
    logic [31:0] sm_out_word;
    logic [2:0]  sm_count;

    instr_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .in_op_type(in_op_type),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_offset(in_offset), .in_immediate(in_immediate),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_word(out_word), .busy(busy), .done(done), .err(err), .count(count)
    );

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(sm_start), .finish(sm_finish),
        .in_valid(sm_in_valid), .in_ready(sm_in_ready), .in_op_type(in_op_type),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_offset(in_offset), .in_immediate(in_immediate),
        .out_valid(sm_out_valid), .out_ready(sm_out_ready), .out_addr(sm_out_addr),
        .out_word(sm_out_word), .busy(sm_busy), .done(sm_done), .err(sm_err),
        .count(sm_count)
    );

    typedef struct {
        logic [4:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] off;
        logic [31:0] imm;
        logic [31:0] word;
        bit          legal;
    } vec_t;

    vec_t vecs[11];
    int   checks   = 0;
    int   failures = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] op, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic [31:0] off, input logic [31:0] imm);
        in_op_type   = op;
        in_rs1       = rs1;
        in_rs2       = rs2;
        in_rd        = rd;
        in_offset    = off;
        in_immediate = imm;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference encoder written from the RV32 format rules with integer range tests
    function automatic void refEncode(input logic [4:0] op, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [4:0] rd,
                                      input logic [31:0] off, input logic [31:0] imm,
                                      output logic [31:0] w, output bit ok);
        int soff;
        int simm;
        logic [2:0] f3;
        soff = $signed(off);
        simm = $signed(imm);
        ok = 1'b1;
        w  = 32'h0;
        f3 = 3'b000;
        case (op)
            I_ADD:  w = {7'h00, rs2, rs1, 3'b000, rd, 7'b0110011};
            I_SUB:  w = {7'h20, rs2, rs1, 3'b000, rd, 7'b0110011};
            I_MUL:  w = {7'h01, rs2, rs1, 3'b000, rd, 7'b0110011};
            I_MULH: w = {7'h01, rs2, rs1, 3'b001, rd, 7'b0110011};
            I_XOR:  w = {7'h00, rs2, rs1, 3'b100, rd, 7'b0110011};
            I_OR:   w = {7'h00, rs2, rs1, 3'b110, rd, 7'b0110011};
            I_AND:  w = {7'h00, rs2, rs1, 3'b111, rd, 7'b0110011};
            I_ADDI: begin
                ok = (simm >= -2048) && (simm <= 2047);
                w  = {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
            end
            I_LW: begin
                ok = (off < 32'd4096);
                w  = {off[11:0], rs1, 3'b010, rd, 7'b0000011};
            end
            I_SW: begin
                ok = (off < 32'd4096);
                w  = {off[11:5], rs2, rs1, 3'b010, off[4:0], 7'b0100011};
            end
            I_BEQ, I_BNE, I_BLT, I_BGE: begin
                if (op == I_BNE) f3 = 3'b001;
                if (op == I_BLT) f3 = 3'b100;
                if (op == I_BGE) f3 = 3'b101;
                ok = (soff % 2 == 0) && (soff >= -4096) && (soff <= 4094);
                w  = {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'b1100011};
            end
            I_JAL: begin
                ok = (soff % 2 == 0) && (soff >= -(1 << 20)) && (soff < (1 << 20));
                w  = {off[20], off[10:1], off[11], off[19:12], rd, 7'b1101111};
            end
            I_LUI: begin
                ok = ((imm & 32'hFFF) == 32'h0);
                w  = {imm[31:12], rd, 7'b0110111};
            end
            I_AUIPC: begin
                ok = ((imm & 32'hFFF) == 32'h0);
                w  = {imm[31:12], rd, 7'b0010111};
            end
            default: ok = 1'b0;
        endcase
    endfunction

    // Random request: mostly in-range operands, occasionally garbage
    task automatic genRandom();
        int sel;
        int v;
        logic [4:0]  op;
        logic [31:0] off;
        logic [31:0] imm;
        sel = $urandom_range(0, 19);
        if (sel <= 17)      op = 5'(sel);
        else if (sel == 18) op = I_ERR;
        else                op = 5'd20;
        off = $urandom;
        imm = $urandom;
        case (op)
            I_ADDI: begin v = $urandom_range(0, 4095); imm = 32'(v - 2048); end
            I_LW, I_SW: off = 32'($urandom_range(0, 4095));
            I_BEQ, I_BNE, I_BLT, I_BGE: begin
                v = $urandom_range(0, 4095); off = 32'((v - 2048) * 2);
            end
            I_JAL: begin
                v = $urandom_range(0, 1048575); off = 32'((v - 524288) * 2);
            end
            I_LUI, I_AUIPC: imm = $urandom & 32'hFFFFF000;
            default: ;
        endcase
        if ($urandom_range(0, 7) == 0) begin
            off = $urandom | 32'h1;
            imm = $urandom | 32'h800;
        end
        applyStimulus(op, 5'($urandom), 5'($urandom), 5'($urandom), off, imm);
    endtask

    initial begin
        logic [9:0]  exp_addr;
        logic [10:0] exp_cnt;
        logic        exp_err;
        logic [41:0] exp_q[$];
        logic [41:0] got_q[$];
        logic [31:0] w;
        bit          ok;
        int          n;

        vecs[0]  = '{I_ADD,  5'd1, 5'd2, 5'd3, 32'd0,  32'd0,         32'h002081B3, 1'b1};
        vecs[1]  = '{I_ADDI, 5'd0, 5'd0, 5'd1, 32'd0,  32'd5,         32'h00500093, 1'b1};
        vecs[2]  = '{I_MUL,  5'd1, 5'd2, 5'd3, 32'd0,  32'd0,         32'h022081B3, 1'b1};
        vecs[3]  = '{I_SW,   5'd1, 5'd2, 5'd0, 32'd4,  32'd0,         32'h0020A223, 1'b1};
        vecs[4]  = '{I_LW,   5'd0, 5'd0, 5'd1, 32'd0,  32'd0,         32'h00002083, 1'b1};
        vecs[5]  = '{I_BEQ,  5'd1, 5'd2, 5'd0, 32'd8,  32'd0,         32'h00208463, 1'b1};
        vecs[6]  = '{I_JAL,  5'd0, 5'd0, 5'd1, 32'd16, 32'd0,         32'h010000EF, 1'b1};
        vecs[7]  = '{I_BEQ,  5'd1, 5'd2, 5'd0, 32'd3,  32'd0,         32'h0,        1'b0};
        vecs[8]  = '{I_ADDI, 5'd0, 5'd0, 5'd1, 32'd0,  32'h800,       32'h0,        1'b0};
        vecs[9]  = '{I_ERR,  5'd1, 5'd2, 5'd3, 32'd0,  32'd0,         32'h0,        1'b0};
        vecs[10] = '{I_LUI,  5'd0, 5'd0, 5'd5, 32'd0,  32'h12345000,  32'h123452B7, 1'b1};

        rst_n = 1'b0; start = 1'b0; finish = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sm_start = 1'b0; sm_finish = 1'b0; sm_in_valid = 1'b0; sm_out_ready = 1'b0;
        applyStimulus(I_NULL, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
        step();
        step();

        checkOutput("rst_in_ready",  in_ready,  0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_busy",      busy,      0);
        checkOutput("rst_done",      done,      0);
        checkOutput("rst_err",       err,       0);
        checkOutput("rst_count",     count,     0);
        checkOutput("rst_out_addr",  out_addr,  0);
        checkOutput("rst_out_word",  out_word,  0);
        rst_n = 1'b1;
        step();

        // Directed table, one request per cycle with the memory always ready
        start = 1'b1; out_ready = 1'b1;
        step();
        start = 1'b0;
        checkOutput("start_busy", busy, 1);
        exp_addr = '0; exp_cnt = '0; exp_err = 1'b0;
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
                          vecs[i].off, vecs[i].imm);
            in_valid = 1'b1;
            #1;
            checkOutput($sformatf("vec%0d_in_ready", i), in_ready, 1);
            step();
            if (vecs[i].legal) begin
                checkOutput($sformatf("vec%0d_out_valid", i), out_valid, 1);
                checkOutput($sformatf("vec%0d_word", i), out_word, vecs[i].word);
                checkOutput($sformatf("vec%0d_addr", i), out_addr, exp_addr);
                exp_addr++;
                exp_cnt++;
            end else begin
                exp_err = 1'b1;
                checkOutput($sformatf("vec%0d_out_valid", i), out_valid, 0);
            end
            checkOutput($sformatf("vec%0d_err", i), err, exp_err);
            checkOutput($sformatf("vec%0d_count", i), count, exp_cnt);
        end

        // Backpressure holds the lui word at address 7 and blocks new requests
        out_ready = 1'b0;
        applyStimulus(I_ADD, 5'd1, 5'd2, 5'd3, 32'd0, 32'd0);
        #1;
        checkOutput("bp_in_ready0", in_ready, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            checkOutput($sformatf("bp%0d_word", k), out_word, 32'h123452B7);
            checkOutput($sformatf("bp%0d_addr", k), out_addr, 7);
            checkOutput($sformatf("bp%0d_valid", k), out_valid, 1);
            checkOutput($sformatf("bp%0d_in_ready", k), in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp_release_in_ready", in_ready, 1);
        step();
        checkOutput("after_bp_word", out_word, 32'h002081B3);
        checkOutput("after_bp_addr", out_addr, 8);

        // finish together with an accepted request: request first, then terminator
        applyStimulus(I_XOR, 5'd1, 5'd2, 5'd4, 32'd0, 32'd0);
        finish = 1'b1;
        step();
        in_valid = 1'b0; finish = 1'b0;
        checkOutput("fin_req_word", out_word, 32'h0020C233);
        checkOutput("fin_req_addr", out_addr, 9);
        checkOutput("fin_term_in_ready", in_ready, 0);
        checkOutput("fin_done_early", done, 0);
        step();
        checkOutput("term_word", out_word, 32'h0);
        checkOutput("term_addr", out_addr, 10);
        checkOutput("term_valid", out_valid, 1);
        checkOutput("term_done", done, 1);
        checkOutput("term_count", count, 10);
        step();
        checkOutput("term_taken", out_valid, 0);
        checkOutput("done_err_sticky", err, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        checkOutput("restart_err", err, 0);
        checkOutput("restart_count", count, 0);
        checkOutput("restart_done", done, 0);

        // Four-slot memory: three instructions fill it, terminator takes the last slot
        sm_start = 1'b1; sm_out_ready = 1'b1;
        step();
        sm_start = 1'b0;
        applyStimulus(I_ADD, 5'd1, 5'd2, 5'd3, 32'd0, 32'd0);
        sm_in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checkOutput($sformatf("sm%0d_addr", k), sm_out_addr, k);
            checkOutput($sformatf("sm%0d_count", k), sm_count, k + 1);
        end
        checkOutput("sm_full_in_ready", sm_in_ready, 0);
        sm_in_valid = 1'b0; sm_finish = 1'b1;
        step();
        sm_finish = 1'b0;
        step();
        checkOutput("sm_term_addr", sm_out_addr, 3);
        checkOutput("sm_term_word", sm_out_word, 0);
        checkOutput("sm_term_valid", sm_out_valid, 1);
        checkOutput("sm_term_done", sm_done, 1);
        checkOutput("sm_term_count", sm_count, 3);
        step();

        // Asynchronous reset mid-stream clears both instances before the next edge
        sm_start = 1'b1;
        step();
        sm_start = 1'b0; sm_out_ready = 1'b0; sm_in_valid = 1'b1;
        step();
        sm_in_valid = 1'b0;
        checkOutput("pre_rst_sm_valid", sm_out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_sm_valid", sm_out_valid, 0);
        checkOutput("arst_sm_busy",  sm_busy,      0);
        checkOutput("arst_sm_count", sm_count,     0);
        checkOutput("arst_sm_addr",  sm_out_addr,  0);
        checkOutput("arst_sm_word",  sm_out_word,  0);
        checkOutput("arst_busy",     busy,         0);
        checkOutput("arst_in_ready", in_ready,     0);
        step();
        rst_n = 1'b1;
        step();

        // Randomized program against the reference encoder and write scoreboard
        start = 1'b1;
        step();
        start = 1'b0;
        exp_addr = '0; exp_cnt = '0; exp_err = 1'b0;
        for (int c = 0; c < 400; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) != 0) begin
                genRandom();
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (out_valid && !out_ready) checkOutput("rnd_bp_in_ready", in_ready, 0);
            if (out_valid && out_ready) got_q.push_back({out_addr, out_word});
            if (in_valid && in_ready) begin
                refEncode(in_op_type, in_rs1, in_rs2, in_rd, in_offset, in_immediate, w, ok);
                if (ok) begin
                    exp_q.push_back({exp_addr, w});
                    exp_addr++;
                    exp_cnt++;
                end else begin
                    exp_err = 1'b1;
                end
            end
            step();
        end
        in_valid = 1'b0;
        finish = 1'b1;
        exp_q.push_back({exp_addr, 32'h0});
        n = 0;
        while (n < 60 && !(done && !out_valid)) begin
            out_ready = ($urandom_range(0, 1) != 0);
            @(negedge clk);
            if (out_valid && out_ready) got_q.push_back({out_addr, out_word});
            step();
            finish = 1'b0;
            n++;
        end
        checkOutput("rnd_term_timeout", (done && !out_valid), 1);
        checkOutput("rnd_count", count, exp_cnt);
        checkOutput("rnd_err", err, exp_err);
        checkOutput("rnd_writes", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checkOutput($sformatf("rnd_addr%0d", i), got_q[i][41:32], exp_q[i][41:32]);
            checkOutput($sformatf("rnd_word%0d", i), got_q[i][31:0], exp_q[i][31:0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
